// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rising-to-rising period of an asynchronous
// PWM input in clk cycles, and flags loss of signal with the stuck level.
module pwm_capture #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             no_signal,
  output logic             stuck_level
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_LOST = 2'd3;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] per;
  } meas_t;

  logic [1:0]       sync_q;
  logic             pwm_s, pwm_d;
  logic             rise, fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CNT_W-1:0] per_inc, hi_inc;
  logic             at_tmo;
  meas_t            meas;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
      pwm_d  <= sync_q[1];
    end
  end

  assign pwm_s = sync_q[1];
  assign rise  = pwm_s & ~pwm_d;
  assign fall  = ~pwm_s & pwm_d;

  // Counters saturate at TIMEOUT so a dead input can never wrap into a bogus period.
  assign at_tmo  = (per_cnt >= TMO);
  assign per_inc = at_tmo ? per_cnt : per_cnt + ONE;
  assign hi_inc  = (hi_cnt >= TMO) ? hi_cnt : hi_cnt + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      meas        <= '0;
      meas_valid  <= 1'b0;
      no_signal   <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise) begin
            per_cnt <= ONE;
            hi_cnt  <= ONE;
            state   <= S_HIGH;
          end else if (at_tmo) begin
            state       <= S_LOST;
            no_signal   <= 1'b1;
            stuck_level <= pwm_s;
          end else begin
            per_cnt <= per_inc;
          end
        end
        S_HIGH: begin
          if (at_tmo) begin
            state       <= S_LOST;
            no_signal   <= 1'b1;
            stuck_level <= pwm_s;
          end else begin
            per_cnt <= per_inc;
            // The fall cycle itself is not counted as high time.
            if (fall) state  <= S_LOW;
            else      hi_cnt <= hi_inc;
          end
        end
        S_LOW: begin
          // A rise landing exactly on the timeout still closes a valid period.
          if (rise) begin
            meas.hi    <= hi_cnt;
            meas.per   <= per_cnt;
            meas_valid <= 1'b1;
            no_signal  <= 1'b0;
            per_cnt    <= ONE;
            hi_cnt     <= ONE;
            state      <= S_HIGH;
          end else if (at_tmo) begin
            state       <= S_LOST;
            no_signal   <= 1'b1;
            stuck_level <= pwm_s;
          end else begin
            per_cnt <= per_inc;
          end
        end
        default: begin
          // Recovery rise only restarts; the next full period publishes.
          if (rise) begin
            per_cnt <= ONE;
            hi_cnt  <= ONE;
            state   <= S_HIGH;
          end
        end
      endcase
    end
  end

  assign high_cnt   = meas.hi;
  assign period_cnt = meas.per;

endmodule
